// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and widths for pipeline PC redirection control
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, SHADOW, HALT} state_t;
  localparam int FLUSH_CNT_W = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (inc && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences PC redirects, flush shadow, halt lock and misalign trap
module pc_redirect_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             ex_halt,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             hz_stall,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             pc_write_en,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t                 state, nxt;
  logic [FLUSH_CNT_W-1:0] sh_cnt;
  logic [PC_W-1:0]        halt_pc;
  logic                   run, mis, halt_ev, redir, stall;
  logic                   unused_bits;
  assign unused_bits = ^ex_target[31:PC_W];
  always_comb begin
    run         = state == RUN;
    mis         = run & ex_valid & ex_redirect & (|ex_target[1:0]);
    halt_ev     = run & ex_valid & (ex_halt | mis);
    redir       = run & ex_valid & ex_redirect & ~halt_ev;
    stall       = run & hz_stall & ~halt_ev & ~redir;
    halted      = state == HALT;
    pc_load     = halted | halt_ev | redir;
    pc_target   = halted ? halt_pc : halt_ev ? ex_pc : redir ? ex_target[PC_W-1:0] : '0;
    pc_write_en = ~halted & ~stall;
    flush_if_id = ~run | halt_ev | redir;
    flush_id_ex = flush_if_id | stall;
    nxt         = halt_ev ? HALT : redir ? SHADOW :
                  (state == SHADOW && sh_cnt == FLUSH_CNT_W'(1)) ? RUN : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state        <= RUN;
      sh_cnt       <= '0;
      halt_pc      <= '0;
      misalign_err <= 1'b0;
    end else begin
      state  <= nxt;
      sh_cnt <= redir ? FLUSH_CNT_W'(FLUSH_CYC - 1) : (state == SHADOW) ? sh_cnt - FLUSH_CNT_W'(1) : sh_cnt;
      if (halt_ev) halt_pc <= ex_pc;
      if (mis) misalign_err <= 1'b1;
    end
  sat_counter #(.W(CNT_W)) u_redirect_cnt (.clk(clk), .reset(reset), .inc(redir), .q(redirect_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(flush_if_id), .q(flush_cnt));
endmodule
